linked_fifo_drain: RTL

Downstream drain scheduler for the shared-memory multi-queue FIFO (`linked_fifo_*`). It snoops the FIFO push interface to track per-queue occupancy and round-robins across non-empty queues, issuing at most one pop per cycle. It captures the FIFO's registered `q` one cycle after each pop and delivers words, tagged with their queue id, on a valid/ready stream through a 3-entry output buffer. It replaces the FIFO's unimplemented `count`/per-queue `empty` with its own bookkeeping.

---
 rtl/linked_fifo_drain.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/linked_fifo_drain.sv
// linked_fifo_drain: round-robin drain scheduler for the shared-memory multi-queue FIFO.
// Latency: 2 cycles from pop to out_valid; sustains one word per cycle when out_ready is high.
// Backpressure: pops are credit-limited to 3 words (buffered + in flight); pop has no path from out_ready.
// Optional feature: define LINKED_FIFO_DRAIN_MASK_EN to add the per-queue queue_en schedule mask.
module linked_fifo_drain #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int FIFOS      = 8,
    parameter int FIFO_LOG2  = (FIFOS > 1) ? $clog2(FIFOS) : 1,
    parameter int DEPTH_LOG2 = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef LINKED_FIFO_DRAIN_MASK_EN
    input  logic [FIFOS-1:0]     queue_en,
`endif
    input  logic                 push,
    input  logic [FIFO_LOG2-1:0] push_fifo,
    output logic                 pop,
    output logic [FIFO_LOG2-1:0] pop_fifo,
    input  logic [WIDTH-1:0]     q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [FIFO_LOG2-1:0] out_fifo,
    output logic                 overflow
);

    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2:0]  cnt [FIFOS];
    logic [FIFO_LOG2-1:0] last;
    logic                 inflight;
    logic [FIFO_LOG2-1:0] inflight_fifo;
    logic [1:0]           buf_cnt;
    logic [WIDTH-1:0]     buf_dat [3];
    logic [FIFO_LOG2-1:0] buf_fifo [3];

    logic [FIFOS-1:0]     eligible;
    logic [FIFOS-1:0]     push_hit;
    logic [FIFOS-1:0]     pop_hit;
    logic                 any_eligible;
    logic [FIFO_LOG2-1:0] winner;
    logic                 credit_ok;
    logic                 capture;
    logic                 xfer;
    logic [1:0]           wr_idx;

    // Per-queue eligibility and push/pop decode for the counters.
    always_comb begin
        for (int i = 0; i < FIFOS; i++) begin
            eligible[i] = (cnt[i] != '0);
`ifdef LINKED_FIFO_DRAIN_MASK_EN
            eligible[i] = eligible[i] && queue_en[i];
`endif
            push_hit[i] = push && (push_fifo == FIFO_LOG2'(i));
            pop_hit[i]  = pop && (pop_fifo == FIFO_LOG2'(i));
        end
    end

    // Round-robin search starting just after the last granted queue.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int k = 1; k <= FIFOS; k++) begin
            if (!any_eligible && eligible[(int'(last) + k) % FIFOS]) begin
                any_eligible = 1'b1;
                winner       = FIFO_LOG2'((int'(last) + k) % FIFOS);
            end
        end
    end

    // Credits cover buffered words plus the word whose q arrives next cycle.
    assign credit_ok = ({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3;
    assign pop       = any_eligible && credit_ok;
    assign pop_fifo  = pop ? winner : '0;

    assign capture   = inflight;
    assign out_valid = (buf_cnt != 2'd0);
    assign xfer      = out_valid && out_ready;
    assign out_data  = buf_dat[0];
    assign out_fifo  = buf_fifo[0];
    // A same-cycle transfer shifts the buffer down, so the tail slot moves with it.
    assign wr_idx    = xfer ? (buf_cnt - 2'd1) : buf_cnt;

    // Occupancy counters; a full queue saturates and raises the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFOS; i++) begin
                cnt[i] <= '0;
            end
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < FIFOS; i++) begin
                if (push_hit[i] && !pop_hit[i]) begin
                    if (cnt[i] != CNT_FULL) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (pop_hit[i] && !push_hit[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (push && (cnt[push_fifo] == CNT_FULL)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Arbiter pointer and the one-cycle in-flight pop tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last          <= '0;
            inflight      <= 1'b0;
            inflight_fifo <= '0;
        end else begin
            inflight      <= pop;
            inflight_fifo <= pop_fifo;
            if (pop) begin
                last <= winner;
            end
        end
    end

    // In-order 3-entry output buffer: head at index 0, captured words appended at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_cnt <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                buf_dat[i]  <= '0;
                buf_fifo[i] <= '0;
            end
        end else begin
            if (xfer) begin
                buf_dat[0]  <= buf_dat[1];
                buf_dat[1]  <= buf_dat[2];
                buf_fifo[0] <= buf_fifo[1];
                buf_fifo[1] <= buf_fifo[2];
            end
            if (capture) begin
                buf_dat[wr_idx]  <= q;
                buf_fifo[wr_idx] <= inflight_fifo;
            end
            if (capture && !xfer) begin
                buf_cnt <= buf_cnt + 2'd1;
            end else if (xfer && !capture) begin
                buf_cnt <= buf_cnt - 2'd1;
            end
        end
    end

endmodule
